dma_axi64_slave_mem: RTL and testbench
======================================

# dma_axi64_slave_mem

Synthesizable AXI3 64-bit slave memory that answers the DMA controller's AXI master port 0: it accepts write bursts (AW/W/B) into an internal word array and serves read bursts (AR/R) from the same array. It sits on the far end of the DMA master channel in the block-level bench and in the FPGA bring-up build, replacing the behavioural responder with real RTL timing. Read and write channels run independently; one outstanding burst per direction.

## Interface
- ID_W, 4, width of AWID/WID/BID/ARID/RID
- ADDR_W, 32, byte-address width
- DEPTH, 1024, number of 64-bit words; valid byte range 0 .. DEPTH*8-1
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- awid/awaddr/awlen/awsize/awvalid  in  ID_W/ADDR_W/4/3/1  write address channel
- awready  out  1
- wid/wdata/wstrb/wlast/wvalid  in  ID_W/64/8/1/1  write data channel
- wready  out  1
- bid/bresp/bvalid  out  ID_W/2/1  write response
- bready  in  1
- arid/araddr/arlen/arsize/arvalid  in  ID_W/ADDR_W/4/3/1  read address channel
- arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  ID_W/64/2/1/1  read data channel
- rready  in  1

## Operation
- Burst type INCR only; length = len+1 (1..16 beats); size ≤ 3; beat n byte address = addr + n*(1<<size); word index = byte address >> 3.
- Write FSM: W_IDLE -> (awvalid&awready) -> W_DATA -> (wvalid&wready&wlast) -> W_RESP -> (bvalid&bready) -> W_IDLE.
- W_IDLE: awready=1, wready=0 (W data before AW is not accepted). AW handshake latches id, addr, len, size; beat counter cleared.
- W_DATA: wready=1; each accepted beat writes bytes where wstrb[i]=1; beat counter increments.
- Burst terminates on wlast only. Beats beyond len+1 are not written. Error flag set if wlast arrives on beat ≠ len, if any beat address ≥ DEPTH*8 (that beat dropped), or if size > 3 (whole burst dropped).
- W_RESP: bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if error flag else 2'b00. wid is not checked.
- Read FSM: R_IDLE -> (arvalid&arready) -> R_DATA -> (rvalid&rready&rlast) -> R_IDLE.
- R_IDLE: arready=1. AR handshake latches id, addr, len, size.
- R_DATA: rvalid=1; rdata=full 64-bit word at current beat address; rid=latched id; rlast=1 on beat len; rresp=SLVERR and rdata=0 for out-of-range beats or size>3, else OKAY. Next beat presented the cycle after each rvalid&rready.
- Same-cycle write and read to the same word: read returns old data (read-before-write).
- Reset asserted mid-burst: both FSMs to IDLE, burst abandoned, memory contents not cleared.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bid=0, bresp=0, arready=0, rvalid=0, rid=0, rdata=0, rresp=0, rlast=0.
- awready and arready rise on the first clk edge after reset deasserts.
- All outputs registered. awready drops the cycle after AW handshake; wready rises that same cycle.
- bvalid asserts 1 cycle after the wlast handshake; held, with bid/bresp stable, until bready.
- First rvalid asserts 1 cycle after AR handshake; rdata/rid/rresp/rlast stable while rvalid&!rready.
- Sustained throughput 1 beat/cycle on W and R with valid/ready both high.
- Minimum burst turnaround: AW accepted again the cycle after B handshake; AR accepted again the cycle after final R handshake.

## Structure
- Shared package dma_axi_pkg: AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, burst-length width constant, write/read FSM state enums.
- One sub-module: dma_axi64_ram — DEPTH x 64 array, one byte-strobed write port, one registered read port (read-before-write).

## Test plan
- Single write awaddr=0x40, awlen=0, wstrb=0xFF, wdata=0x1122334455667788 -> bresp=OKAY; read araddr=0x40 arlen=0 -> rdata=0x1122334455667788, rlast=1, rresp=OKAY.
- 16-beat write at 0x100 (data = beat index), then 16-beat read -> rdata 0..15 in order, rlast only on beat 15, bid/rid echo awid=3/arid=5.
- Partial strobe: word preset 0xFFFF_FFFF_FFFF_FFFF, write wdata=0, wstrb=0x0F -> read back 0xFFFF_FFFF_0000_0000.
- Out of range: DEPTH=1024, write awaddr=0x1FF8 awlen=1 -> beat 0 written, beat 1 dropped, bresp=SLVERR; read same -> beat 1 rdata=0, rresp=SLVERR.
- Early wlast on beat 1 of awlen=3 -> bresp=SLVERR, FSM returns to W_IDLE, next AW accepted.
- Backpressure/concurrency: random bready/rready stalls with overlapping read and write bursts -> no lost/duplicated beats, outputs stable during stalls; reset asserted mid-read -> rvalid=0 immediately, arready=1 one edge after release.

Source files
------------

// File: rtl/dma_axi_pkg.sv
// Shared AXI3 definitions for the DMA slave memory: response codes,
// burst-length width and the write/read channel state encodings.
package dma_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam int         AXI_LEN_W       = 4;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

endpackage

// File: rtl/dma_axi64_ram.sv
// DEPTH x 64-bit word store: byte-strobed write port plus a registered,
// enable-gated read port that returns pre-write data on a same-word collision.
module dma_axi64_ram #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [63:0]      wdata,
    input  logic [7:0]       wstrb,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [63:0]      rdata
);

    logic [63:0] mem [DEPTH];

    // No reset on the array: contents survive a mid-burst reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Only loads on re, so the word holds steady while the R channel stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dma_axi64_slave_mem.sv
// AXI3 64-bit INCR slave memory for the DMA master port: independent write
// (AW/W/B) and read (AR/R) engines, one outstanding burst per direction.
module dma_axi64_slave_mem
    import dma_axi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ID_W-1:0]      awid,
    input  logic [ADDR_W-1:0]    awaddr,
    input  logic [AXI_LEN_W-1:0] awlen,
    input  logic [2:0]           awsize,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [ID_W-1:0]      wid,
    input  logic [63:0]          wdata,
    input  logic [7:0]           wstrb,
    input  logic                 wlast,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [ID_W-1:0]      bid,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    input  logic [ID_W-1:0]      arid,
    input  logic [ADDR_W-1:0]    araddr,
    input  logic [AXI_LEN_W-1:0] arlen,
    input  logic [2:0]           arsize,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [ID_W-1:0]      rid,
    output logic [63:0]          rdata,
    output logic [1:0]           rresp,
    output logic                 rlast,
    output logic                 rvalid,
    input  logic                 rready
);

    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(DEPTH) << 3;

    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [4:0] beat,
                                                    input logic [2:0] size);
        return base + (ADDR_W'(beat) << size);
    endfunction

    function automatic logic beat_bad(input logic [ADDR_W-1:0] a, input logic [2:0] size);
        return (size > 3'd3) || (a >= MEM_BYTES);
    endfunction

    // WID is deliberately ignored; only one write burst is ever in flight.
    logic unused_wid;
    assign unused_wid = ^wid;

    // ---------------- write channel ----------------
    wr_state_e             wstate;
    logic [ADDR_W-1:0]     w_addr;
    logic [AXI_LEN_W-1:0]  w_len;
    logic [2:0]            w_size;
    logic [4:0]            w_beat;
    logic                  w_err;
    logic [ADDR_W-1:0]     w_baddr;
    logic                  w_fire, w_beat_err, w_last_err, ram_we;

    assign w_baddr    = beat_addr(w_addr, w_beat, w_size);
    assign w_fire     = wvalid && wready;
    assign w_beat_err = beat_bad(w_baddr, w_size);
    assign w_last_err = (w_beat != {1'b0, w_len});
    assign ram_we     = w_fire && !w_beat_err && (w_beat <= {1'b0, w_len});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wstate  <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= AXI_RESP_OKAY;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        bid     <= awid;
                        w_beat  <= '0;
                        w_err   <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        // Saturate so a runaway burst never wraps back onto beat 0.
                        if (w_beat != 5'd16) w_beat <= w_beat + 5'd1;
                        w_err <= w_err | w_beat_err;
                        if (wlast) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bresp  <= (w_err || w_beat_err || w_last_err) ? AXI_RESP_SLVERR
                                                                          : AXI_RESP_OKAY;
                            wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wstate  <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    rd_state_e             rstate;
    logic [ADDR_W-1:0]     r_addr;
    logic [AXI_LEN_W-1:0]  r_len;
    logic [2:0]            r_size;
    logic [AXI_LEN_W-1:0]  r_beat;
    logic [ADDR_W-1:0]     r_nxt;
    logic                  ram_re;
    logic [IDX_W-1:0]      ram_raddr;
    logic [63:0]           ram_rdata;

    assign r_nxt = beat_addr(r_addr, {1'b0, r_beat} + 5'd1, r_size);

    // The RAM is fetched one beat ahead: on AR accept and on every non-final R accept.
    always_comb begin
        ram_re    = rvalid && rready && !rlast;
        ram_raddr = r_nxt[IDX_W+2:3];
        if (rstate == R_IDLE) begin
            ram_re    = arvalid && arready;
            ram_raddr = araddr[IDX_W+2:3];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rresp   <= AXI_RESP_OKAY;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_beat  <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        rid     <= arid;
                        r_beat  <= '0;
                        rvalid  <= 1'b1;
                        rlast   <= (arlen == '0);
                        rresp   <= beat_bad(araddr, arsize) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        arready <= 1'b0;
                        rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            rstate  <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                            rlast  <= ((r_beat + 1'b1) == r_len);
                            rresp  <= beat_bad(r_nxt, r_size) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // Error beats (and the idle reset state) read as zero.
    assign rdata = (rresp == AXI_RESP_SLVERR) ? '0 : ram_rdata;

    dma_axi64_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (w_baddr[IDX_W+2:3]),
        .wdata (wdata),
        .wstrb (wstrb),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dma_axi64_slave_mem.sv
// Directed + randomized bench for dma_axi64_slave_mem against a byte-level
// memory model; inputs driven and outputs sampled on the falling clock edge.
module tb_dma_axi64_slave_mem;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 1024;
    localparam logic [31:0] NBYTES = 32'(DEPTH * 8);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [ID_W-1:0]   awid = '0, wid = '0, arid = '0;
    logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
    logic [3:0]        awlen = '0, arlen = '0;
    logic [2:0]        awsize = '0, arsize = '0;
    logic              awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic              arvalid = 1'b0, rready = 1'b0;
    logic [63:0]       wdata = '0;
    logic [7:0]        wstrb = '0;
    logic              awready, wready, bvalid, arready, rvalid, rlast;
    logic [ID_W-1:0]   bid, rid;
    logic [1:0]        bresp, rresp;
    logic [63:0]       rdata;

    dma_axi64_slave_mem #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0]  mb [DEPTH*8];
    logic [63:0] wd [16];
    logic [7:0]  ws [16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mdl_word(input logic [31:0] a);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[j*8 +: 8] = mb[int'(a[31:3]) * 8 + j];
        return w;
    endfunction

    // Write burst of nbeats beats (wlast on the final one) from wd/ws.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input int nbeats);
        logic [31:0] ba;
        logic [1:0]  eresp;
        bit          err;
        int          t, n;
        err = (nbeats != int'(len) + 1) || (size > 3);
        for (int i = 0; i < nbeats; i++) begin
            ba = addr + (32'(i) << size);
            if (ba >= NBYTES) err = 1;
            else if (size <= 3 && i <= int'(len))
                for (int j = 0; j < 8; j++)
                    if (ws[i][j]) mb[int'(ba[31:3]) * 8 + j] = wd[i][j*8 +: 8];
        end
        eresp = err ? 2'b10 : 2'b00;
        awvalid = 1; awid = id; awaddr = addr; awlen = len; awsize = size;
        t = 0;
        while (!awready && t < 200) begin @(negedge clk); t++; end
        chk("aw_wait", 64'(t < 200), 64'd1);
        @(negedge clk);
        awvalid = 0;
        chk("awready_drop", 64'(awready), 64'd0);
        chk("wready_rise", 64'(wready), 64'd1);
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin wvalid = 0; @(negedge clk); end
            wvalid = 1; wid = id; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
            t = 0;
            while (!wready && t < 200) begin @(negedge clk); t++; end
            chk("w_wait", 64'(t < 200), 64'd1);
            @(negedge clk);
        end
        wvalid = 0; wlast = 0;
        chk("bvalid_rise", 64'(bvalid), 64'd1);
        chk("wready_drop", 64'(wready), 64'd0);
        chk("bid", 64'(bid), 64'(id));
        chk("bresp", 64'(bresp), 64'(eresp));
        n = $urandom_range(0, 3);
        repeat (n) begin
            @(negedge clk);
            chk("bvalid_hold", 64'(bvalid), 64'd1);
            chk("bid_hold", 64'(bid), 64'(id));
            chk("bresp_hold", 64'(bresp), 64'(eresp));
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("bvalid_drop", 64'(bvalid), 64'd0);
        chk("awready_back", 64'(awready), 64'd1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size);
        logic [31:0] ba;
        logic [63:0] ed;
        logic [1:0]  er;
        int          t, n;
        arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = size;
        t = 0;
        while (!arready && t < 200) begin @(negedge clk); t++; end
        chk("ar_wait", 64'(t < 200), 64'd1);
        @(negedge clk);
        arvalid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            ba = addr + (32'(i) << size);
            if (size > 3 || ba >= NBYTES) begin ed = '0; er = 2'b10; end
            else begin ed = mdl_word(ba); er = 2'b00; end
            chk("rvalid", 64'(rvalid), 64'd1);
            chk("rdata", rdata, ed);
            chk("rresp", 64'(rresp), 64'(er));
            chk("rlast", 64'(rlast), 64'(i == int'(len)));
            chk("rid", 64'(rid), 64'(id));
            n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            if (n > 0) begin
                rready = 0;
                repeat (n) begin
                    @(negedge clk);
                    chk("rvalid_hold", 64'(rvalid), 64'd1);
                    chk("rdata_hold", rdata, ed);
                    chk("rlast_hold", 64'(rlast), 64'(i == int'(len)));
                end
            end
            rready = 1;
            @(negedge clk);
        end
        rready = 0;
        chk("rvalid_drop", 64'(rvalid), 64'd0);
        chk("arready_back", 64'(arready), 64'd1);
    endtask

    initial begin
        logic [3:0]  len, rlen;
        logic [2:0]  size, rsize;
        logic [31:0] waddr, raddr;
        int          span, t;

        // Reset state and release
        repeat (2) @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_bid_bresp", 64'({bid, bresp}), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_r_out", 64'({rid, rresp, rlast}), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        rst_n = 1;
        #1 chk("awready_pre_edge", 64'(awready), 64'd0);
        @(negedge clk);
        chk("awready_post_rst", 64'(awready), 64'd1);
        chk("arready_post_rst", 64'(arready), 64'd1);

        // Single beat write/read
        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        do_write(4'd1, 32'h40, 4'd0, 3'd3, 1);
        do_read(4'd2, 32'h40, 4'd0, 3'd3);
        chk("single_word", mdl_word(32'h40), 64'h1122334455667788);

        // 16-beat burst, data = beat index
        for (int i = 0; i < 16; i++) begin wd[i] = 64'(i); ws[i] = 8'hFF; end
        do_write(4'd3, 32'h100, 4'd15, 3'd3, 16);
        do_read(4'd5, 32'h100, 4'd15, 3'd3);

        // Partial strobe
        wd[0] = '1; ws[0] = 8'hFF;
        do_write(4'd6, 32'h200, 4'd0, 3'd3, 1);
        wd[0] = '0; ws[0] = 8'h0F;
        do_write(4'd6, 32'h200, 4'd0, 3'd3, 1);
        chk("strobe_model", mdl_word(32'h200), 64'hFFFF_FFFF_0000_0000);
        do_read(4'd7, 32'h200, 4'd0, 3'd3);

        // Last in-range word, second beat past the end
        wd[0] = 64'hA5A5_0000_5A5A_1234; wd[1] = 64'hDEAD_BEEF_0BAD_F00D; ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(4'd8, 32'h1FF8, 4'd1, 3'd3, 2);
        do_read(4'd9, 32'h1FF8, 4'd1, 3'd3);

        // Early wlast, then a normal burst to the same spot
        for (int i = 0; i < 4; i++) begin wd[i] = 64'h3000 + 64'(i); ws[i] = 8'hFF; end
        do_write(4'd10, 32'h300, 4'd3, 3'd3, 2);
        wd[0] = 64'hCAFE; ws[0] = 8'hFF;
        do_write(4'd10, 32'h300, 4'd0, 3'd3, 1);
        do_read(4'd11, 32'h300, 4'd1, 3'd3);

        // size > 3: write dropped, read returns error beats
        wd[0] = 64'h6060; ws[0] = 8'hFF;
        do_write(4'd12, 32'h600, 4'd0, 3'd3, 1);
        wd[0] = 64'hBAD0; wd[1] = 64'hBAD1; ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(4'd12, 32'h600, 4'd1, 3'd4, 2);
        do_read(4'd13, 32'h600, 4'd0, 3'd3);
        do_read(4'd13, 32'h100, 4'd1, 3'd4);

        // Randomized overlapping write/read with stalls (disjoint regions)
        for (int it = 0; it < 12; it++) begin
            len   = 4'($urandom_range(0, 15));
            size  = 3'($urandom_range(0, 3));
            waddr = 32'h800 + (32'($urandom_range(0, 63)) << 3);
            for (int i = 0; i < 16; i++) begin
                wd[i] = {32'($urandom), 32'($urandom)};
                ws[i] = 8'($urandom_range(1, 255));
            end
            rlen  = 4'($urandom_range(0, 15));
            rsize = 3'($urandom_range(0, 3));
            span  = (int'(rlen) + 1) << rsize;
            raddr = 32'h100 + (32'($urandom_range(0, (128 - span) / 8)) << 3);
            fork
                do_write(4'(it), waddr, len, size, int'(len) + 1);
                do_read(~4'(it), raddr, rlen, rsize);
            join
            do_read(4'(it), waddr, len, size);
        end

        // Reset in the middle of a read burst
        arvalid = 1; arid = 4'd14; araddr = 32'h100; arlen = 4'd15; arsize = 3'd3;
        t = 0;
        while (!arready && t < 200) begin @(negedge clk); t++; end
        chk("ar_wait_rst", 64'(t < 200), 64'd1);
        @(negedge clk);
        arvalid = 0; rready = 1;
        repeat (3) @(negedge clk);
        chk("rvalid_before_rst", 64'(rvalid), 64'd1);
        rst_n = 0;
        #1 chk("rvalid_async_rst", 64'(rvalid), 64'd0);
        rready = 0;
        @(negedge clk);
        rst_n = 1;
        #1 chk("arready_at_release", 64'(arready), 64'd0);
        @(negedge clk);
        chk("arready_after_release", 64'(arready), 64'd1);
        do_read(4'd15, 32'h100, 4'd3, 3'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
